// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one iterative AES-128 encrypt core between two valid/ready
//   requesters. Each accepted job is sequenced as load key (only when the key
//   differs from the last one expanded), start, wait for done, then return the
//   ciphertext on the requester's response channel. A watchdog aborts a job
//   whose core never finishes and returns an error response instead.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready/key/plain job request from requester N (N = 0, 1)
//   rspN_valid/ready           response handshake towards requester N
//   rsp_data, rsp_err          shared response payload (err => data is 0)
//   core_key_load, core_start  one-cycle command pulses to the core
//   core_key, core_plain       job operands, held until the next accept
//   core_done, core_cipher     completion pulse and result from the core
//   busy                       high whenever a job is in flight
module aes_core_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_plain,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_plain,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         core_key_load,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_plain,
  input  logic         core_done,
  input  logic [127:0] core_cipher,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         id_q, id_d;
  logic         key_cache_vld_q, key_cache_vld_d;
  logic [127:0] cached_key_q, cached_key_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [127:0] core_key_q, core_key_d;
  logic [127:0] core_plain_q, core_plain_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;
  logic         core_start_q, core_start_d;
  logic         core_key_load_q, core_key_load_d;

  logic         grant;
  logic         accept;
  logic [127:0] sel_key;
  logic [127:0] sel_plain;
  logic         rsp_taken;

  // Round-robin: a lone requester always wins, a tie goes to whoever was
  // not served last.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == S_IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == S_IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign sel_key    = grant ? req1_key   : req0_key;
  assign sel_plain  = grant ? req1_plain : req0_plain;
  assign rsp_taken  = id_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    id_d            = id_q;
    key_cache_vld_d = key_cache_vld_q;
    cached_key_d    = cached_key_q;
    timer_d         = timer_q;
    core_key_d      = core_key_q;
    core_plain_d    = core_plain_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    core_start_d    = 1'b0;
    core_key_load_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          core_key_d   = sel_key;
          core_plain_d = sel_plain;
          id_d         = grant;
          core_start_d = 1'b1;
          // Key-reload decision is made against the incoming key one cycle
          // early so the pulse comes out of a flop during START; the cache
          // cannot change between accept and START.
          core_key_load_d = !key_cache_vld_q || (sel_key != cached_key_q);
          state_d      = S_START;
        end
      end
      S_START: begin
        cached_key_d    = core_key_q;
        key_cache_vld_d = 1'b1;
        timer_d         = '0;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + CNT_W'(1);
        if (core_done) begin
          rsp_data_d = core_cipher;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // A hung core may have a half-expanded key; force a reload.
          rsp_data_d      = '0;
          rsp_err_d       = 1'b1;
          key_cache_vld_d = 1'b0;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_taken) begin
          last_grant_d = id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      last_grant_q    <= 1'b1;
      id_q            <= 1'b0;
      key_cache_vld_q <= 1'b0;
      cached_key_q    <= '0;
      timer_q         <= '0;
      core_key_q      <= '0;
      core_plain_q    <= '0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      core_start_q    <= 1'b0;
      core_key_load_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      id_q            <= id_d;
      key_cache_vld_q <= key_cache_vld_d;
      cached_key_q    <= cached_key_d;
      timer_q         <= timer_d;
      core_key_q      <= core_key_d;
      core_plain_q    <= core_plain_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      core_start_q    <= core_start_d;
      core_key_load_q <= core_key_load_d;
    end
  end

  assign rsp0_valid    = (state_q == S_RESP) && !id_q;
  assign rsp1_valid    = (state_q == S_RESP) &&  id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign core_key_load = core_key_load_q;
  assign core_start    = core_start_q;
  assign core_key      = core_key_q;
  assign core_plain    = core_plain_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
`timescale 1ns/1ps
module tb_aes_core_arbiter;

  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned CNT_W       = 7;
  localparam int unsigned CORE_LAT    = 5;   // start-to-done edges in the core stand-in
  localparam int          LAT_OK      = 7;   // START cycle to first rsp valid cycle
  localparam int          LAT_TO      = 65;  // START cycle to error response cycle

  localparam logic [127:0] K_SPEC = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] P_FIX  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C_SPEC = 128'h4b286e22c5d2113d01227cc2cdf88f39;
  localparam logic [127:0] K_A    = 128'hA5A5A5A5_00000000_12345678_0000FFFF;
  localparam logic [127:0] K_B    = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
  localparam logic [127:0] K_C    = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] K_D    = 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;
  localparam logic [127:0] K_E    = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] K_F    = 128'h80808080_40404040_20202020_10101010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_key = '0, req0_plain = '0, req1_key = '0, req1_plain = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         core_key_load, core_start;
  logic [127:0] core_key, core_plain;
  logic         core_done;
  logic [127:0] core_cipher;
  logic         busy;

  aes_core_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_plain(req0_plain),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_plain(req1_plain),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_key_load(core_key_load), .core_start(core_start),
    .core_key(core_key), .core_plain(core_plain),
    .core_done(core_done), .core_cipher(core_cipher),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] key; logic [127:0] plain; logic load; } start_t;
  typedef struct { logic id; logic [127:0] data; logic err; int lat; } rsp_t;
  start_t start_q[$];
  rsp_t   rsp_q[$];

  // Core stand-in: the known vector for the reference key, XOR otherwise.
  function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p);
    return (k == K_SPEC && p == P_FIX) ? C_SPEC : (k ^ p);
  endfunction

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_start(input logic [127:0] k, input logic [127:0] p, input logic ld);
    start_t s;
    s.key = k; s.plain = p; s.load = ld;
    start_q.push_back(s);
  endfunction

  function automatic void push_rsp(input logic id, input logic [127:0] d, input logic e, input int lat);
    rsp_t r;
    r.id = id; r.data = d; r.err = e; r.lat = lat;
    rsp_q.push_back(r);
  endfunction

  // Core model: hangs (never signals done) while core_hang is set.
  logic         core_hang = 1'b0;
  int unsigned  mcnt;
  logic [127:0] mkey, mplain;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt        <= 0;
      core_done   <= 1'b0;
      core_cipher <= '0;
      mkey        <= '0;
      mplain      <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        mcnt   <= core_hang ? 0 : CORE_LAT;
        mkey   <= core_key;
        mplain <= core_plain;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          core_done   <= 1'b1;
          core_cipher <= model(mkey, mplain);
        end
      end
    end
  end

  // Monitor: core command side and response side, sampled on the falling edge.
  initial begin
    start_t s;
    rsp_t   r;
    logic   prev_v;
    int     start_cyc;
    int     rise_lat;
    prev_v = 1'b0; start_cyc = 0; rise_lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (core_key_load && !core_start) begin
          n_vec++; n_err++;
          $display("FAIL key_load_stray: got 1, expected 0 outside START");
        end
        if (core_start) begin
          start_cyc = cyc;
          if (start_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL start_unexpected: got core_start=1, expected no job");
          end else begin
            s = start_q.pop_front();
            check("core_key", core_key, s.key);
            check("core_plain", core_plain, s.plain);
            check("core_key_load", core_key_load, s.load);
          end
        end
        if (rsp0_valid && rsp1_valid) begin
          n_vec++; n_err++;
          $display("FAIL rsp_both_valid: got 11, expected one-hot");
        end
        if ((rsp0_valid || rsp1_valid) && !prev_v) rise_lat = cyc - start_cyc;
        prev_v = rsp0_valid || rsp1_valid;
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          if (rsp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_unexpected: got rsp%0d, expected none", rsp1_valid);
          end else begin
            r = rsp_q.pop_front();
            check("rsp_id", rsp1_valid, r.id);
            check("rsp_data", rsp_data, r.data);
            check("rsp_err", rsp_err, r.err);
            check("rsp_latency", 128'(rise_lat), 128'(r.lat));
          end
        end
      end
    end
  end

  task automatic issue(input logic id, input logic [127:0] k, input logic [127:0] p);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_key = k; req1_plain = p; end
    else    begin req0_valid = 1'b1; req0_key = k; req0_plain = p; end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout_req%0d: got no ready, expected accept", id);
    end
  endtask

  task automatic drain(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && start_q.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_%s: got %0d pending responses, expected 0", name, rsp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"},
          {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, core_key_load, core_start, busy}, '0);
    check({name, "_rsp_data"}, rsp_data, '0);
    check({name, "_core_key"}, core_key, '0);
    check({name, "_core_plain"}, core_plain, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [127:0] exp_bp;
    logic [127:0] p0 [3];
    logic [127:0] p1 [3];
    logic ok;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single job with the reference vector.
    push_start(K_SPEC, P_FIX, 1'b1);
    push_rsp(1'b0, C_SPEC, 1'b0, LAT_OK);
    issue(1'b0, K_SPEC, P_FIX);
    drain("single");

    // Key cache: reload, hit, reload on a changed key.
    push_start(K_A, 128'h1, 1'b1);        push_rsp(1'b0, model(K_A, 128'h1), 1'b0, LAT_OK);
    push_start(K_A, 128'h2, 1'b0);        push_rsp(1'b0, model(K_A, 128'h2), 1'b0, LAT_OK);
    push_start(K_A + 128'd1, 128'h3, 1'b1); push_rsp(1'b0, model(K_A + 128'd1, 128'h3), 1'b0, LAT_OK);
    issue(1'b0, K_A, 128'h1);
    issue(1'b0, K_A, 128'h2);
    issue(1'b0, K_A + 128'd1, 128'h3);
    drain("cache");

    // Watchdog abort, then the same key must be reloaded.
    @(posedge clk); #1 core_hang = 1'b1;
    push_start(K_B, 128'hFACE, 1'b1);
    push_rsp(1'b0, '0, 1'b1, LAT_TO);
    issue(1'b0, K_B, 128'hFACE);
    drain("timeout");
    @(posedge clk); #1 core_hang = 1'b0;
    push_start(K_B, 128'hBEEF, 1'b1);
    push_rsp(1'b0, model(K_B, 128'hBEEF), 1'b0, LAT_OK);
    issue(1'b0, K_B, 128'hBEEF);
    drain("after_timeout");

    // Response backpressure on requester 1 while requester 0 waits.
    @(posedge clk); #1 rsp1_ready = 1'b0;
    exp_bp = model(K_C, 128'hC1);
    push_start(K_C, 128'hC1, 1'b1); push_rsp(1'b1, exp_bp, 1'b0, LAT_OK);
    push_start(K_C, 128'hC2, 1'b0); push_rsp(1'b0, model(K_C, 128'hC2), 1'b0, LAT_OK);
    issue(1'b1, K_C, 128'hC1);
    fork
      issue(1'b0, K_C, 128'hC2);
    join_none
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp1_valid === 1'b1) begin ok = 1'b1; break; end
    end
    check("bp_rsp1_rises", ok, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (!(rsp1_valid === 1'b1 && rsp_data === exp_bp && rsp_err === 1'b0 && req0_ready === 1'b0)) begin
        n_err++;
        $display("FAIL bp_hold: got valid=%b ready0=%b data=%h, expected valid=1 ready0=0 data=%h",
                 rsp1_valid, req0_ready, rsp_data, exp_bp);
      end
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {busy, req0_ready}, 2'b01);
    drain("backpressure");

    // Reset in the middle of WAIT.
    push_start(K_D, 128'hD1, 1'b0 == 1'b0);
    issue(1'b0, K_D, 128'hD1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midwait_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    push_start(K_D, 128'hD2, 1'b1);
    push_rsp(1'b0, model(K_D, 128'hD2), 1'b0, LAT_OK);
    issue(1'b0, K_D, 128'hD2);
    drain("after_midwait_reset");

    // Fairness with both requesters continuously valid from reset.
    do_reset();
    p0[0] = 128'hE0; p0[1] = 128'hE1; p0[2] = 128'hE2;
    p1[0] = 128'hF0; p1[1] = 128'hF1; p1[2] = 128'hF2;
    for (int j = 0; j < 3; j++) begin
      push_start(K_E, p0[j], 1'b1); push_rsp(1'b0, model(K_E, p0[j]), 1'b0, LAT_OK);
      push_start(K_F, p1[j], 1'b1); push_rsp(1'b1, model(K_F, p1[j]), 1'b0, LAT_OK);
    end
    fork
      begin
        for (int j = 0; j < 3; j++) issue(1'b0, K_E, p0[j]);
      end
      begin
        for (int j = 0; j < 3; j++) issue(1'b1, K_F, p1[j]);
      end
    join
    drain("fairness");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one iterative AES-128 encrypt core between two requesters (req0, req1), each using a valid/ready handshake.
- Sequences the core: load key, start, wait for done, return ciphertext.
- Caches the last loaded key so key expansion is skipped when consecutive jobs use the same key.
- Watchdog timeout returns an error response if the core hangs.
- Sits between the board-level test wrapper/host logic and the AES core.

Parameters:
TIMEOUT_CYC, 64, max cycles in WAIT before abort (must be >= core latency + 1)
CNT_W, 7, timer width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle when valid&ready
req0_key  in  128  requester 0 key
req0_plain  in  128  requester 0 plaintext
req1_valid  in  1  requester 1 has a job
req1_ready  out  1  as req0_ready
req1_key  in  128  requester 1 key
req1_plain  in  128  requester 1 plaintext
rsp0_valid  out  1  response for requester 0
rsp0_ready  in  1  requester 0 takes response
rsp1_valid  out  1  response for requester 1
rsp1_ready  in  1  requester 1 takes response
rsp_data  out  128  ciphertext (shared by both responses)
rsp_err  out  1  1 = timeout abort; rsp_data is 0
core_key_load  out  1  one-cycle pulse: core must re-expand core_key
core_start  out  1  one-cycle pulse: begin encryption
core_key  out  128  key to core, held from START until the next accept
core_plain  out  128  plaintext to core, same hold rule
core_done  in  1  one-cycle pulse: core_cipher valid
core_cipher  in  128  core result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (so req0 wins first), key_cache_vld=0, timer=0. All outputs are 0, including rsp_data, rsp_err, core_key and core_plain.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE arbitration (combinational, round-robin):
  - Only req0 valid: grant=0. Only req1 valid: grant=1.
  - Both valid: grant = ~last_grant.
  - reqN_ready = (state==IDLE) & (grant==N) & reqN_valid. At most one ready high per cycle.
- IDLE accept (valid&ready): latch key/plain into core_key/core_plain, record id=grant, go to START.
- START (exactly 1 cycle):
  - core_start=1.
  - core_key_load=1 iff !key_cache_vld or core_key != cached_key.
  - Then cached_key<=core_key, key_cache_vld<=1, timer<=0, go to WAIT.
- WAIT:
  - timer increments each cycle.
  - core_done=1: rsp_data<=core_cipher, rsp_err<=0, go to RESP.
  - Else if timer==TIMEOUT_CYC-1: rsp_data<=0, rsp_err<=1, key_cache_vld<=0, go to RESP.
  - core_done on the same cycle as timeout expiry: done wins.
  - core_done seen in IDLE, START or RESP is ignored.
- RESP:
  - rsp{id}_valid=1; the other rsp valid stays 0.
  - rsp_data/rsp_err stable while valid.
  - On rsp{id}_ready: last_grant<=id, go to IDLE. New requests are not accepted in that same cycle.
  - Minimum job cost: accept + START + core latency + RESP + 1 idle cycle.
- Requesters may drop or change valid before ready; only the accepted values are used. Inputs are not sampled outside IDLE.
- Latency from accept to rspN_valid = 2 + core latency cycles (accept cycle, START, WAIT cycles incl. done, then RESP).
- rst_n asserted mid-job (any state): immediate return to reset values. Any in-flight response is lost, and key_cache_vld=0 so the next job reloads the key.

Test Plan:
- Single job: req0 key=100F0E0D0C0B0A090807060504030201 (core model fixed plaintext) → one core_key_load and one core_start pulse. rsp0_valid with rsp_data=4b286e22c5d2113d01227cc2cdf88f39, rsp_err=0, rsp1_valid never high.
- Key cache: two back-to-back req0 jobs with the same key → core_key_load pulses on job 1 only. Third job with key+1 → core_key_load pulses again.
- Fairness: req0 and req1 valid continuously for 6 jobs → grants alternate 0,1,0,1,0,1. Each response lands on the matching rspN_valid.
- Timeout: core model never asserts done, TIMEOUT_CYC=64 → rsp0_valid with rsp_err=1, rsp_data=0 exactly 64 cycles after START+1. Next job with the same key asserts core_key_load.
- Backpressure: hold rsp1_ready=0 for 20 cycles → rsp1_valid and rsp_data stay stable, req0_ready stays 0 throughout. Release ready → IDLE next cycle.
- Reset mid-WAIT: drop rst_n for 1 cycle → all outputs 0 immediately. Next job re-asserts core_key_load and completes correctly.
